// File: rtl/uart_defs.sv
// Shared UART definitions: receiver FSM states and receive FIFO sizing.
package uart_defs;

  localparam int UART_ADDR_FIFO  = 3;
  localparam int UART_FIFO_DEPTH = 1 << UART_ADDR_FIFO;

  typedef enum logic [1:0] {
    UART_RX_IDLE,
    UART_RX_START,
    UART_RX_DATA,
    UART_RX_STOP
  } type_uart_rx_states_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered read data; writes while full and reads
// while empty are ignored.
module uart_fifo
  import uart_defs::*;
#(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [W-1:0]            wdata,
  input  logic                    read,
  output logic [W-1:0]            rdata,
  output logic                    empty,
  output logic                    full,
  output logic [UART_ADDR_FIFO:0] count
);

  logic [UART_FIFO_DEPTH-1:0][W-1:0] mem;
  logic [UART_ADDR_FIFO-1:0]         wptr, rptr;
  logic                              do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == (UART_ADDR_FIFO+1)'(UART_FIFO_DEPTH));
  assign do_wr = write & ~full;
  assign do_rd = read & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rdata <= mem[rptr];
        rptr  <= rptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling off a down-counter, 8N1/8N2 framing,
// sticky framing/overrun errors and a watermarked receive FIFO.
module uart_rx
  import uart_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd_pin_i,
  output logic        rx_fifo_empty_o,
  input  logic        rx_fifo_read_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_fifo_mark_o,
  input  logic [2:0]  rx_watermark_i,
  input  logic        rx_en_i,
  input  logic        two_stop_bits_i,
  input  logic [15:0] baud_rate_i,
  output logic        rx_frame_err_o,
  output logic        rx_overrun_o,
  input  logic        err_clr_i
);

  type_uart_rx_states_e state_q, state_d;

  logic                    sync1, rxd_s;
  logic [15:0]             cnt_q, cnt_d;
  logic                    ovf;
  logic [3:0]              bits_q, bits_d;
  logic [7:0]              shift_q, shift_d;
  logic [1:0]              stop_q, stop_d;
  logic                    bad_q, bad_d;
  logic                    push, fe_set, ovr_set;
  logic                    fifo_full;
  logic [UART_ADDR_FIFO:0] fifo_count;

  assign ovf = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd_pin_i;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_RX_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      stop_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = ovf ? cnt_q : cnt_q - 16'd1;
    bits_d  = bits_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    bad_d   = bad_q;
    fe_set  = 1'b0;
    push    = 1'b0;
    case (state_q)
      UART_RX_IDLE: begin
        if (rx_en_i && !rxd_s) begin
          cnt_d   = baud_rate_i >> 1;
          state_d = UART_RX_START;
        end
      end
      UART_RX_START: begin
        if (ovf) begin
          if (!rxd_s) begin
            cnt_d   = baud_rate_i;
            bits_d  = 4'd8;
            state_d = UART_RX_DATA;
          end else begin
            state_d = UART_RX_IDLE;
          end
        end
      end
      UART_RX_DATA: begin
        if (ovf) begin
          shift_d = {rxd_s, shift_q[7:1]};
          bits_d  = bits_q - 4'd1;
          cnt_d   = baud_rate_i;
          if (bits_q == 4'd1) begin
            stop_d  = two_stop_bits_i ? 2'd2 : 2'd1;
            bad_d   = 1'b0;
            state_d = UART_RX_STOP;
          end
        end
      end
      UART_RX_STOP: begin
        if (ovf) begin
          cnt_d  = baud_rate_i;
          stop_d = stop_q - 2'd1;
          if (!rxd_s) begin
            fe_set = 1'b1;
            bad_d  = 1'b1;
          end
          if (stop_q == 2'd1) begin
            push    = !bad_q && rxd_s;
            state_d = UART_RX_IDLE;
          end
        end
      end
      default: state_d = UART_RX_IDLE;
    endcase
    // Disabling abandons the frame outright: no sample, no write, no error.
    if (!rx_en_i) begin
      state_d = UART_RX_IDLE;
      fe_set  = 1'b0;
      push    = 1'b0;
    end
  end

  assign ovr_set = push & fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
    end else begin
      if (fe_set)         rx_frame_err_o <= 1'b1;
      else if (err_clr_i) rx_frame_err_o <= 1'b0;
      if (ovr_set)        rx_overrun_o   <= 1'b1;
      else if (err_clr_i) rx_overrun_o   <= 1'b0;
    end
  end

  // Hysteresis: equality keeps the previous flag value.
  always_ff @(posedge clk) begin
    if (rst) rx_fifo_mark_o <= 1'b0;
    else if (fifo_count > {1'b0, rx_watermark_i}) rx_fifo_mark_o <= 1'b1;
    else if (fifo_count < {1'b0, rx_watermark_i}) rx_fifo_mark_o <= 1'b0;
  end

  uart_fifo #(.W(8)) rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .write (push & ~fifo_full),
    .wdata (shift_q),
    .read  (rx_fifo_read_i),
    .rdata (rx_data_o),
    .empty (rx_fifo_empty_o),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx; expectations come from a byte-queue model
// of the receive path (frame -> error flag or FIFO entry).
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        empty;
  logic        rd;
  logic [7:0]  rx_data;
  logic        mark;
  logic [2:0]  wm;
  logic        en;
  logic        two;
  logic [15:0] baud;
  logic        fe;
  logic        ovr;
  logic        clr;

  int chk_cnt = 0;
  int fail_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] last_data;
  logic [7:0] d;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk             (clk),
    .rst             (rst),
    .rxd_pin_i       (rxd),
    .rx_fifo_empty_o (empty),
    .rx_fifo_read_i  (rd),
    .rx_data_o       (rx_data),
    .rx_fifo_mark_o  (mark),
    .rx_watermark_i  (wm),
    .rx_en_i         (en),
    .two_stop_bits_i (two),
    .baud_rate_i     (baud),
    .rx_frame_err_o  (fe),
    .rx_overrun_o    (ovr),
    .err_clr_i       (clr)
  );

  // All stimulus tasks start and end at a falling edge.
  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (int'(baud) + 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic s1, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Reference: a frame with any low stop bit only raises the framing error;
  // a good frame lands in the queue unless eight bytes are already waiting.
  task automatic model_frame(input logic [7:0] b, input logic s1, input logic s2,
                             inout logic fe_m, inout logic ovr_m);
    if (!s1 || (two && !s2)) fe_m = 1'b1;
    else if (q.size() == 8) ovr_m = 1'b1;
    else q.push_back(b);
  endtask

  task automatic rd_byte(output logic [7:0] v);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    v = rx_data;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({empty, mark, fe, ovr, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got e%b m%b fe%b ov%b d%h want e1 m0 fe0 ov0 d00",
               empty, mark, fe, ovr, rx_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    baud = 16'd15; two = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b1);
    chk_cnt++;
    if (empty !== 1'b0) begin fail_cnt++; $display("FAIL basic_not_empty: got %b want 0", empty); end
    rd_byte(d);
    chk_cnt++;
    if (d !== 8'hA5) begin fail_cnt++; $display("FAIL basic_data: got %h want a5", d); end
    chk_cnt++;
    if ({fe, ovr, empty} !== 3'b001) begin
      fail_cnt++; $display("FAIL basic_flags: got fe%b ov%b e%b want 0 0 1", fe, ovr, empty);
    end
    last_data = 8'hA5;
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b1);
    chk_cnt++;
    if ({fe, empty} !== 2'b11) begin
      fail_cnt++; $display("FAIL frame_err_set: got fe%b e%b want fe1 e1", fe, empty);
    end
    pulse_clr();
    chk_cnt++;
    if (fe !== 1'b0) begin fail_cnt++; $display("FAIL frame_err_clr: got %b want 0", fe); end
  endtask

  task automatic test_false_start;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk_cnt++;
    if ({empty, fe, ovr} !== 3'b100) begin
      fail_cnt++; $display("FAIL false_start: got e%b fe%b ov%b want 1 0 0", empty, fe, ovr);
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b1);
    chk_cnt++;
    if (ovr !== 1'b1) begin fail_cnt++; $display("FAIL overrun_flag: got %b want 1", ovr); end
    for (int i = 0; i < 8; i++) begin
      rd_byte(d);
      chk_cnt++;
      if (d !== 8'(i)) begin fail_cnt++; $display("FAIL overrun_read%0d: got %h want %h", i, d, 8'(i)); end
    end
    chk_cnt++;
    if (empty !== 1'b1) begin fail_cnt++; $display("FAIL overrun_drained: got %b want 1", empty); end
    last_data = 8'h07;
    pulse_clr();
    chk_cnt++;
    if (ovr !== 1'b0) begin fail_cnt++; $display("FAIL overrun_clr: got %b want 0", ovr); end
  endtask

  task automatic test_watermark;
    wm = 3'd3;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
    chk_cnt++;
    if (mark !== 1'b1) begin fail_cnt++; $display("FAIL mark_set: got %b want 1", mark); end
    rd_byte(d);
    @(negedge clk);
    chk_cnt++;
    if (mark !== 1'b1) begin fail_cnt++; $display("FAIL mark_hold_equal: got %b want 1", mark); end
    rd_byte(d);
    @(negedge clk);
    chk_cnt++;
    if (mark !== 1'b0) begin fail_cnt++; $display("FAIL mark_clear: got %b want 0", mark); end
    rd_byte(d);
    rd_byte(d);
    chk_cnt++;
    if (d !== 8'h13) begin fail_cnt++; $display("FAIL mark_last_read: got %h want 13", d); end
    last_data = 8'h13;
    wm = 3'd7;
  endtask

  task automatic test_two_stop;
    two = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    chk_cnt++;
    if ({fe, empty} !== 2'b11) begin
      fail_cnt++; $display("FAIL two_stop_err: got fe%b e%b want fe1 e1", fe, empty);
    end
    send_frame(8'h81, 1'b1, 1'b1);
    rd_byte(d);
    chk_cnt++;
    if (d !== 8'h81) begin fail_cnt++; $display("FAIL two_stop_good: got %h want 81", d); end
    last_data = 8'h81;
    two = 1'b0;
    pulse_clr();
  endtask

  task automatic test_rx_disable;
    send_frame(8'h66, 1'b1, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    en = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (12 * 16) @(negedge clk);
    rd_byte(d);
    chk_cnt++;
    if (d !== 8'h66) begin fail_cnt++; $display("FAIL disable_kept: got %h want 66", d); end
    chk_cnt++;
    if ({empty, fe} !== 2'b10) begin
      fail_cnt++; $display("FAIL disable_abandon: got e%b fe%b want e1 fe0", empty, fe);
    end
    rd_byte(d);
    chk_cnt++;
    if (d !== 8'h66) begin fail_cnt++; $display("FAIL empty_read_hold: got %h want 66", d); end
    last_data = 8'h66;
  endtask

  task automatic test_random;
    logic fe_m = 1'b0;
    logic ovr_m = 1'b0;
    logic [7:0] b;
    logic s1, s2;
    q.delete();
    for (int i = 0; i < 14; i++) begin
      baud = 16'($urandom_range(7, 31));
      two  = 1'($urandom_range(0, 1));
      b    = 8'($urandom);
      s1   = ($urandom_range(0, 5) != 0);
      s2   = ($urandom_range(0, 5) != 0);
      send_frame(b, s1, s2);
      model_frame(b, s1, s2, fe_m, ovr_m);
      chk_cnt++;
      if ({fe, ovr, empty} !== {fe_m, ovr_m, q.size() == 0}) begin
        fail_cnt++;
        $display("FAIL rand_flags%0d: got fe%b ov%b e%b want fe%b ov%b e%b",
                 i, fe, ovr, empty, fe_m, ovr_m, q.size() == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int k = $urandom_range(0, 3); k > 0; k--) begin
          rd_byte(d);
          if (q.size() != 0) last_data = q.pop_front();
          chk_cnt++;
          if (d !== last_data) begin
            fail_cnt++; $display("FAIL rand_read%0d: got %h want %h", i, d, last_data);
          end
        end
      end
    end
    while (q.size() != 0) begin
      rd_byte(d);
      last_data = q.pop_front();
      chk_cnt++;
      if (d !== last_data) begin fail_cnt++; $display("FAIL rand_drain: got %h want %h", d, last_data); end
    end
    pulse_clr();
    baud = 16'd15; two = 1'b0;
  endtask

  task automatic test_reset_mid;
    wm = 3'd0;
    send_frame(8'h42, 1'b1, 1'b1);
    send_frame(8'h24, 1'b0, 1'b1);
    chk_cnt++;
    if ({mark, fe, empty} !== 3'b110) begin
      fail_cnt++; $display("FAIL pre_reset_state: got m%b fe%b e%b want 1 1 0", mark, fe, empty);
    end
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({empty, mark, fe, ovr, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fail_cnt++;
      $display("FAIL reset_mid: got e%b m%b fe%b ov%b d%h want e1 m0 fe0 ov0 d00",
               empty, mark, fe, ovr, rx_data);
    end
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wm = 3'd7;
    repeat (12 * 16) @(negedge clk);
    chk_cnt++;
    if ({empty, fe} !== 2'b10) begin
      fail_cnt++; $display("FAIL reset_mid_discard: got e%b fe%b want e1 fe0", empty, fe);
    end
    send_frame(8'h5A, 1'b1, 1'b1);
    rd_byte(d);
    chk_cnt++;
    if (d !== 8'h5A) begin fail_cnt++; $display("FAIL post_reset_rx: got %h want 5a", d); end
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rd = 1'b0; wm = 3'd7; en = 1'b1;
    two = 1'b0; baud = 16'd15; clr = 1'b0; last_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_watermark();
    test_two_stop();
    test_rx_disable();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", chk_cnt - fail_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port rxd_pin_i  input  1  asynchronous serial line; idle high.
REQ-004 SHALL have port rx_fifo_empty_o  output  1  high when the receive FIFO holds no bytes.
REQ-005 SHALL have port rx_fifo_read_i  input  1  one-cycle pop request.
REQ-006 SHALL have port rx_data_o  output  8  byte popped by the last accepted read.
REQ-007 SHALL have port rx_fifo_mark_o  output  1  FIFO count is above the watermark.
REQ-008 SHALL have port rx_watermark_i  input  3  watermark level.
REQ-009 SHALL have port rx_en_i  input  1  receiver enable.
REQ-010 SHALL have port two_stop_bits_i  input  1  expect two stop bits.
REQ-011 SHALL have port baud_rate_i  input  16  bit period minus one, in clk cycles (P = baud_rate_i+1).
REQ-012 SHALL have port rx_frame_err_o  output  1  sticky framing error.
REQ-013 SHALL have port rx_overrun_o  output  1  sticky overrun error.
REQ-014 SHALL have port err_clr_i  input  1  one-cycle pulse; clears both sticky errors.

Function
REQ-015 SHALL pass rxd_pin_i through a 2-flop synchronizer reset to 1; all decisions SHALL use the synchronized value (rxd_s).
REQ-016 SHALL implement FSM states UART_RX_IDLE, UART_RX_START, UART_RX_DATA and UART_RX_STOP, using a 16-bit down-counter that asserts ovf at 0.
REQ-017 IDLE: if rx_en_i=1 and rxd_s=0, SHALL load the counter with baud_rate_i>>1 and go to START; otherwise SHALL stay in IDLE.
REQ-018 START: at ovf, SHALL re-sample rxd_s. If rxd_s=0, SHALL load the counter with baud_rate_i, load a bit count of 8, and go to DATA. If rxd_s=1 (false start), SHALL return to IDLE with no FIFO write and no error.
REQ-019 DATA: at each ovf, SHALL shift rxd_s into shifter bit 7 (LSB first on the line), decrement the bit count, and reload the counter. After the 8th sample, SHALL go to STOP with the stop count set to 2 if two_stop_bits_i=1, else 1.
REQ-020 STOP: at each ovf, SHALL sample rxd_s. Any 0 sample SHALL set rx_frame_err_o. When the last stop sample is taken, SHALL go to IDLE.
REQ-021 On leaving STOP with no framing error, SHALL write the byte into the FIFO in that same cycle. If the FIFO is full, SHALL drop the byte and set rx_overrun_o, even if a read occurs in the same cycle.
REQ-022 A frame with a framing error SHALL be discarded and never written to the FIFO.
REQ-023 rx_en_i=0 in any state SHALL force IDLE on the next cycle and abandon the partial frame; FIFO contents SHALL be kept.
REQ-024 An accepted read (rx_fifo_read_i=1 and FIFO not empty) SHALL update rx_data_o on the next cycle. A read while empty SHALL be ignored, and rx_data_o SHALL hold.
REQ-025 When a set condition and err_clr_i occur in the same cycle, the set SHALL win.
REQ-026 rx_fifo_mark_o SHALL be a registered flag: set when count > rx_watermark_i, cleared when count < rx_watermark_i, and held when they are equal.
REQ-027 baud_rate_i and two_stop_bits_i SHALL be sampled only at counter loads; changes mid-bit SHALL take effect at the next load.

Reset
REQ-028 While rst=1: state SHALL be IDLE; counter, bit count, shifter and rx_data_o SHALL be 0; synchronizer SHALL be 1; FIFO SHALL be empty.
REQ-029 While rst=1, outputs SHALL be: rx_fifo_empty_o=1, rx_fifo_mark_o=0, rx_frame_err_o=0, rx_overrun_o=0.
REQ-030 Reset mid-frame SHALL discard the frame, and the first cycle after reset SHALL be IDLE.

Structure
REQ-031 type_uart_rx_states_e and UART_ADDR_FIFO (FIFO depth 8) SHALL live in the shared uart_defs package.
REQ-032 SHALL instantiate the existing sub-module uart_fifo as rx_fifo; no other sub-modules.

Verification
REQ-033 baud_rate_i=15, frame 0xA5 (1 stop bit), then read -> rx_data_o=0xA5; both errors stay 0; rx_fifo_empty_o is 1 again after the read.
REQ-034 baud_rate_i=15, 0x3C sent with a 0 stop bit -> rx_frame_err_o=1; FIFO stays empty; err_clr_i pulse -> rx_frame_err_o=0.
REQ-035 rxd low pulse of 4 cycles, baud_rate_i=15 -> no FIFO write and no error flags.
REQ-036 9 bytes 0x00..0x08 received with no reads -> rx_overrun_o=1; 8 reads return 0x00..0x07.
REQ-037 rx_watermark_i=3, receive 4 bytes -> rx_fifo_mark_o=1; read 2 bytes -> rx_fifo_mark_o=0.
REQ-038 two_stop_bits_i=1, 0x81 with first stop=1 and second stop=0 -> rx_frame_err_o=1 and no write; rst asserted mid-DATA -> all outputs at their reset values the next cycle.
